// File: rtl/dffrnq_pipe_if.sv
// dffrnq_pipe_if: valid/ready bus of the elastic register pipeline.
// master = producer/consumer side, slave = the pipeline itself.
interface dffrnq_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] D;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Q;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, D, out_ready,
    input  in_ready, out_valid, Q, count
  );

  modport slave (
    input  in_valid, D, out_ready,
    output in_ready, out_valid, Q, count
  );
endinterface

// File: rtl/dffrnq_pipe.sv
// dffrnq_pipe: WIDTH x DEPTH elastic register pipeline, collapsing bubbles, valid/ready on both ends.
// DFFRNQ_PIPE_SCAN_EN adds SE/SI/SO: one scan chain through all data registers, handshake frozen while SE=1.
module dffrnq_pipe #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic         CLK,
  input  logic         RN,
`ifdef DFFRNQ_PIPE_SCAN_EN
  input  logic         SE,
  input  logic         SI,
  output logic         SO,
`endif
  dffrnq_pipe_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d_q   [DEPTH];
  logic [WIDTH-1:0] d_nxt [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_nxt;
  logic             scan;

`ifdef DFFRNQ_PIPE_SCAN_EN
  localparam int unsigned TW = WIDTH * DEPTH;

  logic [TW-1:0] chain;
  logic [TW-1:0] chain_shift;

  assign scan = SE;
  assign SO   = d_q[DEPTH-1][WIDTH-1];

  // Flattened data registers, bit 0 = d[0][0]; SI enters at the bottom, SO leaves at the top.
  always_comb begin
    chain = '0;
    for (int i = 0; i < DEPTH; i++) chain[i*WIDTH +: WIDTH] = d_q[i];
    chain_shift = (chain << 1) | TW'(SI);
  end
`else
  assign scan = 1'b0;
`endif

  // A stage can load when it or any stage downstream of it frees up this cycle.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
    assign rdy[i] = bus.out_ready | ~(&v_q[DEPTH-1:i]);
  end

  // Upstream source for every stage: the input port for stage 0, the previous stage otherwise.
  always_comb begin
    src_v    = (v_q << 1) | DEPTH'(bus.in_valid);
    src_d[0] = bus.D;
    for (int i = 1; i < DEPTH; i++) src_d[i] = d_q[i-1];
  end

  // Next state: advance ready stages (data only moves with a valid word), or shift the scan chain.
  always_comb begin
    v_nxt   = v_q;
    d_nxt   = d_q;
    cnt_nxt = '0;
    if (!scan) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v_nxt[i] = src_v[i];
          if (src_v[i]) d_nxt[i] = src_d[i];
        end
      end
    end
`ifdef DFFRNQ_PIPE_SCAN_EN
    else begin
      for (int i = 0; i < DEPTH; i++) d_nxt[i] = chain_shift[i*WIDTH +: WIDTH];
    end
`endif
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + CW'(v_nxt[i]);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= RESET_VAL;
    end else begin
      v_q   <= v_nxt;
      cnt_q <= cnt_nxt;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_nxt[i];
    end
  end

  assign bus.in_ready  = rdy[0] & ~scan;
  assign bus.out_valid = v_q[DEPTH-1] & ~scan;
  assign bus.Q         = d_q[DEPTH-1];
  assign bus.count     = cnt_q;

endmodule

// File: tb/tb_dffrnq_pipe.sv
// tb_dffrnq_pipe: directed and random stimulus against a queue-of-words reference model.
// Scan chain is exercised when DFFRNQ_PIPE_SCAN_EN is defined.
module tb_dffrnq_pipe;

  localparam int unsigned      WIDTH   = 8;
  localparam int unsigned      DEPTH   = 3;
  localparam int               DEP     = 3;
  localparam logic [WIDTH-1:0] RST_VAL = 8'h00;

  logic CLK = 1'b0;
  logic RN  = 1'b0;
`ifdef DFFRNQ_PIPE_SCAN_EN
  logic SE = 1'b0;
  logic SI = 1'b0;
  logic SO;
`endif

  dffrnq_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dffrnq_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RST_VAL)) dut (
    .CLK (CLK),
    .RN  (RN),
`ifdef DFFRNQ_PIPE_SCAN_EN
    .SE  (SE),
    .SI  (SI),
    .SO  (SO),
`endif
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: words in flight, oldest first, with the stage each one occupies.
  logic [WIDTH-1:0] m_word [$];
  int               m_pos  [$];
  logic [WIDTH-1:0] m_q;

  task automatic model_reset();
    m_word.delete();
    m_pos.delete();
    m_q = RST_VAL;
  endtask

  // One clock: drive after the falling edge, check before the rising edge, then advance the model.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] din, input logic ordy);
    logic ov, ir;
    int   lim, np;
    @(negedge CLK);
    bus.in_valid  = iv;
    bus.D         = din;
    bus.out_ready = ordy;
    #1;
    ov = (m_pos.size() > 0) && (m_pos[0] == DEP - 1);
    ir = (m_word.size() < DEP) || ordy;
    check("out_valid", 32'(bus.out_valid), 32'(ov));
    check("in_ready",  32'(bus.in_ready),  32'(ir));
    check("count",     32'(bus.count),     32'(m_word.size()));
    check("Q",         32'(bus.Q),         32'(m_q));
    @(posedge CLK);
    if (ov && ordy) begin
      void'(m_word.pop_front());
      void'(m_pos.pop_front());
    end
    // Each word moves one stage forward unless blocked by the word ahead of it.
    lim = DEP - 1;
    for (int k = 0; k < m_pos.size(); k++) begin
      np = (m_pos[k] + 1 < lim) ? m_pos[k] + 1 : lim;
      m_pos[k] = np;
      lim = np - 1;
    end
    if (iv && ir) begin
      m_word.push_back(din);
      m_pos.push_back(0);
    end
    if (m_pos.size() > 0 && m_pos[0] == DEP - 1) m_q = m_word[0];
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear with no clock edge.
  task automatic async_reset(input string tag);
    @(negedge CLK);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    #2;
    RN = 1'b0;
    #1;
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_count"},     32'(bus.count),     32'd0);
    check({tag, "_Q"},         32'(bus.Q),         32'(RST_VAL));
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    model_reset();
    @(posedge CLK);
    #1;
    check({tag, "_count_hold"}, 32'(bus.count), 32'd0);
    @(negedge CLK);
    RN = 1'b1;
    bus.in_valid = 1'b0;
  endtask

`ifdef DFFRNQ_PIPE_SCAN_EN
  task automatic scan_test();
    logic [23:0] pat;
    logic        sent [48];
    pat = 24'hC3A55A;
    cycle(1'b1, 8'h77, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    @(negedge CLK);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    SE = 1'b1;
    for (int m = 1; m <= 48; m++) begin
      SI = (m <= 24) ? pat[24-m] : 1'b0;
      sent[m-1] = SI;
      #1;
      check("scan_in_ready",  32'(bus.in_ready),  32'd0);
      check("scan_out_valid", 32'(bus.out_valid), 32'd0);
      check("scan_count",     32'(bus.count),     32'd1);
      @(posedge CLK);
      #1;
      if (m >= 24) check("scan_SO", 32'(SO), 32'(sent[m-24]));
      @(negedge CLK);
    end
    SE = 1'b0;
    #1;
    check("scan_exit_in_ready",  32'(bus.in_ready),  32'd1);
    check("scan_exit_out_valid", 32'(bus.out_valid), 32'd1);
    check("scan_exit_count",     32'(bus.count),     32'd1);
    check("scan_exit_Q",         32'(bus.Q),         32'd0);
    async_reset("scan_rst");
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.D         = '0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count",     32'(bus.count),     32'd0);
    check("rst_Q",         32'(bus.Q),         32'(RST_VAL));
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge CLK);
    RN = 1'b1;

    // Streaming 0x00..0x0F with both sides always ready.
    for (int i = 0; i < 16; i++) cycle(1'b1, WIDTH'(i), 1'b1);
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    // Backpressure: fill, hold 0x44 off, then release with a simultaneous in/out.
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    cycle(1'b1, 8'h44, 1'b0);
    cycle(1'b1, 8'h44, 1'b0);
    cycle(1'b1, 8'h44, 1'b1);
    repeat (5) cycle(1'b0, 8'h00, 1'b1);

    // Full pipeline streaming through with out_ready held high.
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(8'hB0 + i), 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, WIDTH'(8'hC0 + i), 1'b1);
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    // Bubble collapse: a lone word drifts to the output stage without out_ready.
    cycle(1'b1, 8'h5A, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    repeat (2) cycle(1'b0, 8'h00, 1'b1);

    // Reset with two words in flight, then a fresh word.
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    async_reset("mid_rst");
    cycle(1'b1, 8'hA5, 1'b1);
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    // Random traffic with alternating consumer stall phases.
    for (int n = 0; n < 800; n++) begin
      logic iv, ordy;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ((n / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cycle(iv, WIDTH'($urandom), ordy);
    end
    repeat (5) cycle(1'b0, 8'h00, 1'b1);

`ifdef DFFRNQ_PIPE_SCAN_EN
    scan_test();
    cycle(1'b1, 8'h3C, 1'b1);
    repeat (4) cycle(1'b0, 8'h00, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
